iter_mult_param: RTL and testbench

- Parametrised iterative shift-add multiplier. It is the next-generation sequential multiply unit for the CPU execute stage.
- Adds the following over the fixed 32-bit unit:
  - generic operand width
  - per-operation signed/unsigned mode
  - explicit ready/busy/done handshake
  - asynchronous reset
  - a registered, held product
- Executes one multiplier bit per cycle on magnitudes, then applies a sign fix-up state.

---
 rtl/iter_mult_pkg.sv | 26 ++
 rtl/iter_mult_abs.sv | 28 ++
 rtl/iter_mult_param.sv | 129 ++++++++++++
 tb/tb_iter_mult_param.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package iter_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Widest value the negate helper handles: a 2*64-bit product.
    localparam int NEG_MAX_W = 128;

    // Two's-complement negate when en=1, pass-through otherwise. Callers
    // zero-extend narrower values; the low bits of the result are still
    // the correct narrow negation.
    function automatic logic [NEG_MAX_W-1:0] cond_neg(input logic [NEG_MAX_W-1:0] value,
                                                      input logic                 en);
        return en ? (~value + NEG_MAX_W'(1)) : value;
    endfunction

endpackage

// File: rtl/iter_mult_abs.sv
// Conditional two's-complement negate of a W-bit value (operand abs / product fix-up).
// Latency: purely combinational.
// Backpressure: not applicable.
module iter_mult_abs
    import iter_mult_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] in_val,
    input  logic         neg_en,
    output logic [W-1:0] out_val
);

    logic [NEG_MAX_W-1:0] neg_wide;

    // Negate in the package's widest format, then keep the low W bits.
    always_comb begin
        neg_wide = cond_neg(NEG_MAX_W'(in_val), neg_en);
    end

    assign out_val = neg_wide[W-1:0];

    if (W < NEG_MAX_W) begin : g_hi
        logic hi_unused;
        assign hi_unused = ^neg_wide[NEG_MAX_W-1:W];
    end

endmodule

// File: rtl/iter_mult_param.sv
// Iterative shift-add multiplier on operand magnitudes with a final sign fix-up; ITER_MULT_EARLY_TERM_EN enables early exit.
// Latency: WIDTH+2 cycles accept-to-done (early exit: highest set bit of |op2| + 3, minimum 3).
// Backpressure: mult_begin is taken only when mult_ready=1; requests while busy or done are dropped, not queued.
module iter_mult_param
    import iter_mult_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mult_begin,
    input  logic               mult_signed,
    input  logic [WIDTH-1:0]   mult_op1,
    input  logic [WIDTH-1:0]   mult_op2,
    output logic               mult_ready,
    output logic               mult_busy,
    output logic               mult_end,
    output logic [2*WIDTH-1:0] product
);

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;

    logic [WIDTH-1:0]   op1_mag, op2_mag, mplier_shift;
    logic [2*WIDTH-1:0] prod_fix;
    logic [CNT_W-1:0]   cnt_inc;
    logic               calc_last;

    iter_mult_abs #(.W(WIDTH)) u_abs_op1 (
        .in_val  (mult_op1),
        .neg_en  (mult_signed & mult_op1[WIDTH-1]),
        .out_val (op1_mag)
    );

    iter_mult_abs #(.W(WIDTH)) u_abs_op2 (
        .in_val  (mult_op2),
        .neg_en  (mult_signed & mult_op2[WIDTH-1]),
        .out_val (op2_mag)
    );

    // A zero accumulator negates to zero, so a zero result never turns negative.
    iter_mult_abs #(.W(2*WIDTH)) u_abs_res (
        .in_val  (acc_q),
        .neg_en  (neg_q),
        .out_val (prod_fix)
    );

    // Next-state and datapath: capture at accept, one multiplier bit per CALC cycle, fix-up in SIGN.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        neg_d        = neg_q;
        product_d    = product_q;
        cnt_inc      = cnt_q + CNT_W'(1);
        mplier_shift = mplier_q >> 1;
`ifdef ITER_MULT_EARLY_TERM_EN
        calc_last    = (cnt_inc == CNT_W'(WIDTH)) || (mplier_shift == '0);
`else
        calc_last    = (cnt_inc == CNT_W'(WIDTH));
`endif
        case (state_q)
            IDLE: begin
                if (mult_begin) begin
                    state_d  = CALC;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, op1_mag};
                    mplier_d = op2_mag;
                    cnt_d    = '0;
                    neg_d    = mult_signed & (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
                end
            end
            CALC: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift;
                cnt_d    = cnt_inc;
                if (calc_last) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                product_d = prod_fix;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign mult_ready = (state_q == IDLE);
    assign mult_busy  = (state_q == CALC) || (state_q == SIGN);
    assign mult_end   = (state_q == DONE);
    assign product    = product_q;

endmodule

// File: tb/tb_iter_mult_param.sv
// Self-checking bench: directed WIDTH=32 cases plus a random sweep at WIDTH=4,8,17,64.
// Latency: expected done cycle comes from the reference model (honours ITER_MULT_EARLY_TERM_EN).
// Backpressure: checks that requests while busy/done are dropped and re-accepted after DONE.
module tb_iter_mult_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIDTH=32 unit for directed tests
    logic        m_begin, m_sgn, m_rdy, m_busy, m_end;
    logic [31:0] m_op1, m_op2;
    logic [63:0] m_prod;

    // Sweep units: index 0..3 -> WIDTH 4, 8, 17, 64
    logic [3:0]   s_begin, s_sgn, s_rdy, s_busy, s_end;
    logic [63:0]  s_op1 [4];
    logic [63:0]  s_op2 [4];
    logic [7:0]   p4;
    logic [15:0]  p8;
    logic [33:0]  p17;
    logic [127:0] p64;
    logic [127:0] s_prod [4];

    assign s_prod[0] = 128'(p4);
    assign s_prod[1] = 128'(p8);
    assign s_prod[2] = 128'(p17);
    assign s_prod[3] = p64;

    int n_vec = 0;
    int n_err = 0;

    iter_mult_param #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .mult_begin(m_begin), .mult_signed(m_sgn),
        .mult_op1(m_op1), .mult_op2(m_op2), .mult_ready(m_rdy),
        .mult_busy(m_busy), .mult_end(m_end), .product(m_prod)
    );

    iter_mult_param #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .mult_begin(s_begin[0]), .mult_signed(s_sgn[0]),
        .mult_op1(s_op1[0][3:0]), .mult_op2(s_op2[0][3:0]), .mult_ready(s_rdy[0]),
        .mult_busy(s_busy[0]), .mult_end(s_end[0]), .product(p4)
    );

    iter_mult_param #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .mult_begin(s_begin[1]), .mult_signed(s_sgn[1]),
        .mult_op1(s_op1[1][7:0]), .mult_op2(s_op2[1][7:0]), .mult_ready(s_rdy[1]),
        .mult_busy(s_busy[1]), .mult_end(s_end[1]), .product(p8)
    );

    iter_mult_param #(.WIDTH(17)) u_w17 (
        .clk(clk), .rst(rst), .mult_begin(s_begin[2]), .mult_signed(s_sgn[2]),
        .mult_op1(s_op1[2][16:0]), .mult_op2(s_op2[2][16:0]), .mult_ready(s_rdy[2]),
        .mult_busy(s_busy[2]), .mult_end(s_end[2]), .product(p17)
    );

    iter_mult_param #(.WIDTH(64)) u_w64 (
        .clk(clk), .rst(rst), .mult_begin(s_begin[3]), .mult_signed(s_sgn[3]),
        .mult_op1(s_op1[3]), .mult_op2(s_op2[3]), .mult_ready(s_rdy[3]),
        .mult_busy(s_busy[3]), .mult_end(s_end[3]), .product(p64)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_vec++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic int sw(input int j);
        case (j)
            0:       return 4;
            1:       return 8;
            2:       return 17;
            default: return 64;
        endcase
    endfunction

    // Reference product: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [127:0] ref_prod(input int w, input logic [127:0] a,
                                              input logic [127:0] b, input logic sgn);
        logic [127:0] sa, sb;
        sa = a;
        sb = b;
        if (sgn && a[w-1]) sa = a - (128'd1 << w);
        if (sgn && b[w-1]) sb = b - (128'd1 << w);
        return (sa * sb) & ((128'd1 << (2 * w)) - 128'd1);
    endfunction

    // Reference latency: cycles from the accept edge to the cycle mult_end is seen.
    function automatic int ref_lat(input int w, input logic [127:0] b, input logic sgn);
`ifdef ITER_MULT_EARLY_TERM_EN
        logic [127:0] mag;
        int calc;
        mag  = (sgn && b[w-1]) ? ((128'd1 << w) - b) : b;
        calc = 1;
        for (int i = 0; i < w; i++) if (mag[i]) calc = i + 1;
        return calc + 2;
`else
        if (sgn && b[0]) return w + 2;
        return w + 2;
`endif
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] r;
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        if (w == 64) mask = '1;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       r = '0;
            1:       r = '1;
            2:       r = 64'd1 << (w - 1);
            default: r = r;
        endcase
        return r & mask;
    endfunction

    task automatic run_main(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic sgn);
        int lat;
        int seen;
        logic [127:0] exp_p;
        lat   = ref_lat(32, 128'(b), sgn);
        exp_p = ref_prod(32, 128'(a), 128'(b), sgn);
        seen  = 0;
        @(negedge clk);
        chk({tag, "_ready"}, 128'(m_rdy), 128'(1));
        m_begin = 1'b1; m_sgn = sgn; m_op1 = a; m_op2 = b;
        @(negedge clk);
        m_begin = 1'b0; m_sgn = ~sgn; m_op1 = $urandom; m_op2 = $urandom;
        chk({tag, "_busy"}, {126'd0, m_busy, m_rdy}, 128'd2);
        for (int i = 1; i <= 200 && seen == 0; i++) begin
            if (i > 1) @(negedge clk);
            if (m_end) seen = i;
        end
        chk({tag, "_latency"}, 128'(seen), 128'(lat));
        chk({tag, "_product"}, 128'(m_prod), exp_p);
        @(negedge clk);
        chk({tag, "_end_width"}, {126'd0, m_end, m_rdy}, 128'd1);
        chk({tag, "_held"}, 128'(m_prod), exp_p);
    endtask

    task automatic run_hold();
        int L;
        int ends;
        logic [127:0] p1, p2;
        L    = ref_lat(32, 128'd3, 1'b0);
        p1   = ref_prod(32, 128'd5, 128'd3, 1'b0);
        p2   = ref_prod(32, 128'((L + 1) * 13 + 5), 128'd3, 1'b0);
        ends = 0;
        m_sgn = 1'b0; m_op2 = 32'd3;
        for (int i = 0; i <= 2 * L + 2; i++) begin
            @(negedge clk);
            if (m_end) ends++;
            chk($sformatf("hold_end_%0d", i), 128'(m_end), 128'((i == L) || (i == 2 * L + 1)));
            if (i == L)         chk("hold_prod1", 128'(m_prod), p1);
            if (i == L + 1)     chk("hold_ready", 128'(m_rdy), 128'd1);
            if (i == L + 2)     chk("hold_busy2", 128'(m_busy), 128'd1);
            if (i == 2 * L)     chk("hold_prod1_stable", 128'(m_prod), p1);
            if (i == 2 * L + 1) chk("hold_prod2", 128'(m_prod), p2);
            if (i <= 2 * L + 1) begin
                m_begin = 1'b1;
                m_op1   = 32'(i * 13 + 5);
            end else begin
                m_begin = 1'b0;
            end
        end
        chk("hold_end_count", 128'(ends), 128'd2);
    endtask

    task automatic run_reset_abort();
        int ends;
        ends = 0;
        @(negedge clk);
        m_begin = 1'b1; m_sgn = 1'b0; m_op1 = 32'd99; m_op2 = 32'd77;
        @(negedge clk);
        m_begin = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_busy", 128'(m_busy), 128'd1);
        rst = 1'b1;
        #1;
        chk("rst_ready", 128'(m_rdy), 128'd1);
        chk("rst_busy_end", {126'd0, m_busy, m_end}, 128'd0);
        chk("rst_product", 128'(m_prod), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_end) ends++;
        end
        chk("rst_no_end", 128'(ends), 128'd0);
        chk("rst_product_after", 128'(m_prod), 128'd0);
    endtask

    task automatic run_sweep(input int iters);
        logic [127:0] exp_p [4];
        int lat [4];
        int ends [4];
        int maxl;
        for (int it = 0; it < iters; it++) begin
            @(negedge clk);
            maxl = 0;
            for (int j = 0; j < 4; j++) begin
                s_op1[j]   = pick(sw(j));
                s_op2[j]   = pick(sw(j));
                s_sgn[j]   = 1'($urandom_range(0, 1));
                s_begin[j] = 1'b1;
                exp_p[j]   = ref_prod(sw(j), 128'(s_op1[j]), 128'(s_op2[j]), s_sgn[j]);
                lat[j]     = ref_lat(sw(j), 128'(s_op2[j]), s_sgn[j]);
                ends[j]    = 0;
                if (lat[j] > maxl) maxl = lat[j];
            end
            @(negedge clk);
            s_begin = '0;
            for (int j = 0; j < 4; j++) begin
                s_op1[j] = {$urandom, $urandom};
                s_op2[j] = {$urandom, $urandom};
            end
            for (int c = 1; c <= maxl + 1; c++) begin
                if (c > 1) @(negedge clk);
                for (int j = 0; j < 4; j++) begin
                    if (s_end[j]) ends[j]++;
                    if (c == lat[j]) begin
                        chk($sformatf("sweep_w%0d_end_%0d", sw(j), it), 128'(s_end[j]), 128'd1);
                        chk($sformatf("sweep_w%0d_prod_%0d", sw(j), it), s_prod[j], exp_p[j]);
                    end
                end
            end
            for (int j = 0; j < 4; j++)
                chk($sformatf("sweep_w%0d_endcnt_%0d", sw(j), it), 128'(ends[j]), 128'd1);
        end
    endtask

    initial begin
        rst = 1'b1;
        m_begin = 1'b0; m_sgn = 1'b0; m_op1 = '0; m_op2 = '0;
        s_begin = '0; s_sgn = '0;
        for (int j = 0; j < 4; j++) begin
            s_op1[j] = '0;
            s_op2[j] = '0;
        end
        #1;
        chk("reset_ready", 128'(m_rdy), 128'd1);
        chk("reset_busy_end", {126'd0, m_busy, m_end}, 128'd0);
        chk("reset_product", 128'(m_prod), 128'd0);
        chk("reset_sweep_ready", 128'(s_rdy), 128'hF);
        #20;
        @(negedge clk);
        rst = 1'b0;

        run_main("umax",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_main("s_m7x3",   32'hFFFF_FFF9, 32'd3,         1'b1);
        run_main("s_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1);
        run_main("s_5xm1",   32'd5,         32'hFFFF_FFFF, 1'b1);
        run_main("s_5x2",    32'd5,         32'd2,         1'b1);
        run_main("s_123x0",  32'd123,       32'd0,         1'b1);
        run_main("s_m1x0",   32'hFFFF_FFFF, 32'd0,         1'b1);
        run_main("u_rand",   $urandom,      $urandom,      1'b0);
        run_hold();
        run_reset_abort();
        run_sweep(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
